// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage M-extension sequencer: funct3 codes,
// FSM state encoding and the default datapath width.
package ex_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider on a
// shared 2*XLEN accumulator: {hi, lo} = {partial product, multiplier} or {remainder, quotient}.
module muldiv_step
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   divisor,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : {(XLEN+1){1'b0}});
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge      = shifted >= {1'b0, divisor};
    // When ge holds the true difference is below 2^XLEN, so the low bits are exact.
    diff    = shifted[XLEN-1:0] - divisor;
    if (is_div) begin
      acc_next = {(ge ? diff : shifted[XLEN-1:0]), acc[XLEN-2:0], ge};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M sequencer for EX: latches operand magnitudes, iterates muldiv_step
// XLEN times, then restores signs and selects the result; stalls the pipeline meanwhile.
module ex_muldiv_seq
  import ex_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  // Handshake: an op is taken on any edge where start=1, flush=0 and the sequencer is
  // IDLE or DONE; stall then stays high until the DONE cycle, which pulses result_valid.
  state_t state, state_next;
  logic   accept;

  logic            a_signed, b_signed, a_neg, b_neg, div0, ovf, special_now;
  logic [XLEN-1:0] abs_a, abs_b, special_val_now;

  logic [2:0]        fn_q;
  logic [2*XLEN-1:0] acc_q, acc_next;
  logic [XLEN-1:0]   opb_q, special_val_q, result_q, fin_value;
  logic              neg_ab_q, neg_a_q, special_q;
  logic [CW-1:0]     count_q;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  always_comb begin
    a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    b_signed = a_signed && (funct3 != F3_MULHSU);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    abs_a    = a_neg ? -op_a : op_a;
    abs_b    = b_neg ? -op_b : op_b;
    div0     = funct3[2] && (op_b == '0);
    ovf      = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special_now = div0 | ovf;
    if (div0) special_val_now = funct3[1] ? op_a : '1;
    else      special_val_now = funct3[1] ? '0 : op_a;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) state_next = (FAST_SPECIAL && special_now) ? S_FIN : S_BUSY;
          else       state_next = S_IDLE;
        end
        S_BUSY:  if (count_q == '0) state_next = S_FIN;
        S_FIN:   state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    accept       = start && !flush && ((state == S_IDLE) || (state == S_DONE));
    stall        = accept || (state == S_BUSY) || (state == S_FIN);
    result_valid = (state == S_DONE);
    dbg_state    = state;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_q),
    .divisor  (opb_q),
    .is_div   (fn_q[2]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn_q          <= '0;
      acc_q         <= '0;
      opb_q         <= '0;
      neg_ab_q      <= 1'b0;
      neg_a_q       <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      count_q       <= '0;
    end else if (accept) begin
      fn_q          <= funct3;
      acc_q         <= {{XLEN{1'b0}}, abs_a};
      opb_q         <= abs_b;
      neg_ab_q      <= a_neg ^ b_neg;
      neg_a_q       <= a_neg;
      special_q     <= special_now;
      special_val_q <= special_val_now;
      count_q       <= CW'(XLEN - 1);
    end else if (state == S_BUSY) begin
      acc_q   <= acc_next;
      count_q <= count_q - 1'b1;
    end
  end

  // Remainder follows the dividend's sign; quotient and product follow the sign XOR.
  always_comb begin
    prod = neg_ab_q ? -acc_q : acc_q;
    quot = neg_ab_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (special_q)         fin_value = special_val_q;
    else if (!fn_q[2])     fin_value = (fn_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else                   fin_value = fn_q[1] ? rem : quot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            result_q <= '0;
    else if ((state == S_FIN) && !flush) result_q <= fin_value;
  end

  assign result = result_q;

endmodule
